// File: rtl/kgp_mem_pkg.sv
// kgp_mem_pkg: shared types, constants and address checks for the KGP-RISC data-memory responder
// Optional feature macro: DMEM_BYTE_STROBE_EN (byte-strobe legality rules in is_bad_addr)
package kgp_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int WORD_BYTES = 4;
  localparam int WAIT_CNT_W = 4;
  function automatic logic out_of_range(input logic [31:0] a, input int aw);
    return (a >> (aw + 2)) != 32'd0;
  endfunction
`ifdef DMEM_BYTE_STROBE_EN
  // Legal when the set strobes form one contiguous run starting at the byte offset.
  // An empty strobe is an error on a store; an empty-strobe load needs word alignment.
  function automatic logic is_bad_addr(input logic [31:0] a, input int aw, input logic [3:0] be, input logic we);
    logic [1:0] lo;
    logic [3:0] s;
    lo = be[0] ? 2'd0 : be[1] ? 2'd1 : be[2] ? 2'd2 : 2'd3;
    s = be >> lo;
    if (be == 4'd0) return we || a[1:0] != 2'd0 || out_of_range(a, aw);
    return a[1:0] != lo || (s & (s + 4'd1)) != 4'd0 || out_of_range(a, aw);
  endfunction
`else
  function automatic logic is_bad_addr(input logic [31:0] a, input int aw);
    return a[1:0] != 2'd0 || out_of_range(a, aw);
  endfunction
`endif
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word RAM, read data registered when en is high
// Ports: clk, en (access strobe), we (write), be (byte enables, DMEM_BYTE_STROBE_EN only),
//        addr (word index), wdata, rdata (registered read of addr)
module dmem_array
  import kgp_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]        be,
`endif
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (en) begin
`ifdef DMEM_BYTE_STROBE_EN
      for (int i = 0; i < WORD_BYTES; i++)
        if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
`else
      if (we) mem[addr] <= wdata;
`endif
      rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store target for the KGP-RISC core with fixed wait states before the response
// Ports: clk, rst (async, active-high); request req_valid/req_ready/req_we/req_addr/req_wdata
//        (+ req_be under DMEM_BYTE_STROBE_EN); response rsp_valid/rsp_ready/rsp_rdata/rsp_err
module dmem_responder
  import kgp_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]        req_be,
`endif
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  state_t state, next;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [DATA_W-1:0] q;
  logic accept, bad, lat_ld;
  assign accept = req_valid && req_ready;
`ifdef DMEM_BYTE_STROBE_EN
  assign bad = is_bad_addr(req_addr, ADDR_W, req_be, req_we);
`else
  assign bad = is_bad_addr(req_addr, ADDR_W);
`endif
  dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk  (clk),
    .en   (accept),
    .we   (req_we && !bad),
`ifdef DMEM_BYTE_STROBE_EN
    .be   (req_be),
`endif
    .addr (req_addr[ADDR_W+1:2]),
    .wdata(req_wdata),
    .rdata(q)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // WAIT always lasts WAIT_CYCLES+1 cycles so the RAM read is captured before RESP
  always_comb
    next = state == IDLE ? (accept ? WAIT : IDLE) :
           state == WAIT ? (cnt == '0 ? RESP : WAIT) :
           (rsp_ready ? IDLE : RESP);
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt       <= '0;
      lat_ld    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      cnt       <= WAIT_CNT_W'(WAIT_CYCLES);
      lat_ld    <= !req_we && !bad;
      rsp_rdata <= '0;
      rsp_err   <= bad;
    end else if (state == WAIT) begin
      cnt    <= cnt == '0 ? cnt : cnt - 1'b1;
      lat_ld <= 1'b0;
      if (lat_ld) rsp_rdata <= q;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table-driven check of two responders (WAIT_CYCLES=2 and 0) sharing one request stream
module tb_dmem_responder;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready2, rsp_valid2, rsp_err2, req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata2, rsp_rdata0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2));
  dmem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0));

  typedef struct {
    string       nm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          hold;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic xact(input vec_t v);
    int l2, l0;
    @(negedge clk);
    chk({v.nm, " req_ready"}, {31'd0, req_ready2 & req_ready0}, 32'd1);
    req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1;
    req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    l2 = 0; l0 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid0 && l0 == 0) l0 = n;
      if (rsp_valid2 && l2 == 0) l2 = n;
      if (l2 != 0) break;
    end
    chk({v.nm, " latency w2"}, l2, 32'd3);
    chk({v.nm, " latency w0"}, l0, 32'd1);
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1; req_we = 1; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      chk({v.nm, " hold valid"}, {30'd0, rsp_valid2, rsp_valid0}, 32'd3);
      chk({v.nm, " hold ready"}, {30'd0, req_ready2, req_ready0}, 32'd0);
      chk({v.nm, " hold rdata"}, rsp_rdata2, v.rdata);
    end
    req_valid = 0;
    chk({v.nm, " rdata w2"}, rsp_rdata2, v.rdata);
    chk({v.nm, " rdata w0"}, rsp_rdata0, v.rdata);
    chk({v.nm, " err"}, {30'd0, rsp_err2, rsp_err0}, {30'd0, v.err, v.err});
    rsp_ready = 1;
    @(posedge clk);
    #1;
    rsp_ready = 0;
    chk({v.nm, " post hs"}, {28'd0, rsp_valid2, rsp_valid0, req_ready2, req_ready0}, 32'd3);
  endtask

  initial begin
    vecs[0]  = '{"st 10",      1, 32'h10,       32'hDEADBEEF, 32'h0,        0, 0};
    vecs[1]  = '{"ld 10 stall",0, 32'h10,       32'h0,        32'hDEADBEEF, 0, 5};
    vecs[2]  = '{"ld 13 mis",  0, 32'h13,       32'h0,        32'h0,        1, 0};
    vecs[3]  = '{"ld 10 again",0, 32'h10,       32'h0,        32'hDEADBEEF, 0, 0};
    vecs[4]  = '{"st 0",       1, 32'h0,        32'h12345678, 32'h0,        0, 0};
    vecs[5]  = '{"st 1000 oor",1, 32'h1000,     32'hAAAA5555, 32'h0,        1, 0};
    vecs[6]  = '{"ld 0",       0, 32'h0,        32'h0,        32'h12345678, 0, 0};
    vecs[7]  = '{"st ffc",     1, 32'hFFC,      32'h0BADF00D, 32'h0,        0, 0};
    vecs[8]  = '{"ld ffc",     0, 32'hFFC,      32'h0,        32'h0BADF00D, 0, 0};
    vecs[9]  = '{"ld hi oor",  0, 32'h80000000, 32'h0,        32'h0,        1, 0};
    vecs[10] = '{"st 2 mis",   1, 32'h2,        32'h55555555, 32'h0,        1, 0};
    vecs[11] = '{"ld 0 again", 0, 32'h0,        32'h0,        32'h12345678, 0, 0};
    #1;
    chk("reset outs", {rsp_rdata2[3:0], rsp_rdata0[3:0], 2'd0, rsp_valid2, rsp_valid0, rsp_err2, rsp_err0, req_ready2, req_ready0}, 32'h3);
    chk("reset rdata", rsp_rdata2 | rsp_rdata0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    foreach (vecs[i]) xact(vecs[i]);
    // reset while both responders are mid-transaction
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 0;
    rst = 1;
    #1;
    chk("mid rst ready", {30'd0, req_ready2, req_ready0}, 32'd3);
    chk("mid rst valid", {30'd0, rsp_valid2, rsp_valid0}, 32'd0);
    @(negedge clk);
    rst = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      chk("no rsp after rst", {30'd0, rsp_valid2, rsp_valid0}, 32'd0);
    end
    xact('{"ld 10 post rst", 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
